// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage PC register, next-PC sequencer and halt drain FSM.
// Optional performance counters are enabled with `define PC_PERF_CNT_EN.
module fetch_pc_unit #(
    parameter int PC_W         = 9,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [31:0]     br_pc,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            flush,
    output logic            halted,
`ifdef PC_PERF_CNT_EN
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     stall_cnt,
`endif
    output logic            misalign
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            mis_q, mis_d;
    logic [PC_W-1:0] redirect_target;
    logic            redirect;
    logic            unused_br_hi;

    // Upper target bits lie outside instruction memory and are dropped.
    assign unused_br_hi    = ^br_pc[31:PC_W];
    assign redirect_target = {br_pc[PC_W-1:2], 2'b00};
    assign redirect        = pc_sel && (state_q != HALTED);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        case (state_q)
            RUN: begin
                if (pc_sel) begin
                    pc_d = redirect_target;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    state_d = DRAIN;
                    cnt_d   = 4'(DRAIN_CYCLES - 1);
                end else begin
                    pc_d = pc_q + PC_W'(4);
                end
            end
            DRAIN: begin
                // A redirect while draining means the halt was on the wrong path.
                if (pc_sel) begin
                    state_d = RUN;
                    pc_d    = redirect_target;
                end else if (cnt_q == 4'd0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
        if (redirect && (br_pc[1:0] != 2'b00)) begin
            mis_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            cnt_q   <= 4'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc          = pc_q;
    assign misalign    = mis_q;
    assign halted      = (state_q == HALTED);
    assign fetch_valid = reset && (state_q == RUN);
    assign flush       = reset && redirect;

`ifdef PC_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        in_run;

    assign in_run = (state_q == RUN);

    always_comb begin
        fetch_cnt_d    = fetch_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (in_run && !stall && !pc_sel && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (in_run && pc_sel && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
        if (in_run && stall && !pc_sel && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign fetch_cnt    = fetch_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed table-driven bench for fetch_pc_unit.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        pc_sel;
    logic [31:0] br_pc;
    logic        halt;
    logic [8:0]  pc;
    logic        fetch_valid;
    logic        flush;
    logic        halted;
    logic        misalign;
`ifdef PC_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.PC_W(9), .DRAIN_CYCLES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .pc_sel      (pc_sel),
        .br_pc       (br_pc),
        .halt        (halt),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .halted      (halted),
`ifdef PC_PERF_CNT_EN
        .fetch_cnt   (fetch_cnt),
        .redirect_cnt(redirect_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        pc_sel;
        logic        halt;
        logic [31:0] br_pc;
        logic        e_flush;
        logic [8:0]  e_pc;
        logic        e_fv;
        logic        e_halted;
        logic        e_mis;
    } vec_t;

    vec_t va[10];
    vec_t vb[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive after the falling edge, check flush combinationally, then state after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        stall  = v.stall;
        pc_sel = v.pc_sel;
        halt   = v.halt;
        br_pc  = v.br_pc;
        #1;
        chk({tag, " flush"}, 32'(flush), 32'(v.e_flush));
        @(posedge clk);
        #1;
        chk({tag, " pc"}, 32'(pc), 32'(v.e_pc));
        chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'(v.e_fv));
        chk({tag, " halted"}, 32'(halted), 32'(v.e_halted));
        chk({tag, " misalign"}, 32'(misalign), 32'(v.e_mis));
    endtask

    task automatic idle;
        @(negedge clk);
        stall = 1'b0; pc_sel = 1'b0; halt = 1'b0; br_pc = 32'h0;
    endtask

    initial begin
        //           stall pc_sel halt  br_pc          flush  pc      fv    halted mis
        va[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b0};
        va[1] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h044, 1'b1, 1'b0, 1'b0};
        va[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h044, 1'b1, 1'b0, 1'b0};
        va[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0123, 1'b1, 9'h120, 1'b1, 1'b0, 1'b1};
        va[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FE20, 1'b1, 9'h020, 1'b1, 1'b0, 1'b1};
        va[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 9'h020, 1'b0, 1'b0, 1'b1};
        va[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h020, 1'b0, 1'b0, 1'b1};
        va[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 9'h020, 1'b0, 1'b0, 1'b1};
        va[8] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h020, 1'b0, 1'b1, 1'b1};
        va[9] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 9'h020, 1'b0, 1'b1, 1'b1};

        vb[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0030, 1'b1, 9'h030, 1'b1, 1'b0, 1'b0};
        vb[1]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 9'h030, 1'b0, 1'b0, 1'b0};
        vb[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h030, 1'b0, 1'b0, 1'b0};
        vb[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 1'b1, 9'h080, 1'b1, 1'b0, 1'b0};
        vb[4]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h084, 1'b1, 1'b0, 1'b0};
        vb[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h088, 1'b1, 1'b0, 1'b0};
        vb[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 9'h100, 1'b1, 1'b0, 1'b0};
        vb[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h104, 1'b1, 1'b0, 1'b0};
        vb[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 9'h104, 1'b1, 1'b0, 1'b0};
        vb[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h108, 1'b1, 1'b0, 1'b0};
        vb[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 9'h108, 1'b0, 1'b0, 1'b0};
        vb[11] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 9'h108, 1'b0, 1'b0, 1'b0};
        vb[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h108, 1'b0, 1'b0, 1'b0};
        vb[13] = '{1'b0, 1'b1, 1'b0, 32'h0000_01FC, 1'b1, 9'h1FC, 1'b1, 1'b0, 1'b0};
        vb[14] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0};
        vb[15] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        vb[16] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        vb[17] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        vb[18] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0};

        // Reset with a redirect pending: outputs must stay quiet.
        reset = 1'b0; stall = 1'b0; pc_sel = 1'b1; halt = 1'b0; br_pc = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        chk("rst pc", 32'(pc), 32'h0);
        chk("rst fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst flush", 32'(flush), 32'h0);
        chk("rst halted", 32'(halted), 32'h0);
        chk("rst misalign", 32'(misalign), 32'h0);
        idle();
        reset = 1'b1;

        // Sequential fetch through the 512-byte wrap, ending at 0x010.
        for (int k = 1; k <= 132; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seq pc k=%0d", k), 32'(pc), (k * 4) % 512);
            chk("seq fetch_valid", 32'(fetch_valid), 32'h1);
        end

        for (int i = 0; i < 10; i++) apply(va[i], $sformatf("va[%0d]", i));

        // Sticky misalign and frozen HALTED state over 20 more cycles.
        idle();
        repeat (20) @(posedge clk);
        #1;
        chk("halted hold", 32'(halted), 32'h1);
        chk("halted pc", 32'(pc), 32'h020);
        chk("misalign sticky", 32'(misalign), 32'h1);

        // Asynchronous reset mid-cycle in HALTED.
        #2;
        reset = 1'b0;
        #1;
        chk("async pc", 32'(pc), 32'h0);
        chk("async halted", 32'(halted), 32'h0);
        chk("async fetch_valid", 32'(fetch_valid), 32'h0);
        chk("async misalign", 32'(misalign), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release fetch_valid", 32'(fetch_valid), 32'h1);
        chk("release pc", 32'(pc), 32'h0);
        @(posedge clk);
        #1;
        chk("resume pc", 32'(pc), 32'h004);

        for (int i = 0; i < 19; i++) apply(vb[i], $sformatf("vb[%0d]", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
